// File: rtl/axil_picorv32_mem_bridge_pkg.sv
// Shared definitions for the AXI4-Lite to PicoRV32 native memory bridge:
// response codes, FSM state encoding and a small response helper.
package axil_picorv32_mem_bridge_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MEM_WR = 3'd1,
      ST_MEM_RD = 3'd2,
      ST_B_RESP = 3'd3,
      ST_R_RESP = 3'd4
   } bridgeState_e;

   function automatic logic [1:0] respCode(input logic err);
      return err ? RESP_SLVERR : RESP_OKAY;
   endfunction

endpackage

// File: rtl/axil_picorv32_mem_bridge.sv
// AXI4-Lite slave that replays each AXI transaction as one PicoRV32 native
// memory request; one transaction in flight, single clock domain.
module axil_picorv32_mem_bridge
   import axil_picorv32_mem_bridge_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      S_AXI_ACLK,
   input  logic                      S_AXI_ARESETN,
   input  logic                      S_AXI_AWVALID,
   output logic                      S_AXI_AWREADY,
   input  logic [AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [2:0]                S_AXI_AWPROT,
   input  logic                      S_AXI_WVALID,
   output logic                      S_AXI_WREADY,
   input  logic [31:0]               S_AXI_WDATA,
   input  logic [3:0]                S_AXI_WSTRB,
   output logic                      S_AXI_BVALID,
   input  logic                      S_AXI_BREADY,
   output logic [1:0]                S_AXI_BRESP,
   input  logic                      S_AXI_ARVALID,
   output logic                      S_AXI_ARREADY,
   input  logic [AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [2:0]                S_AXI_ARPROT,
   output logic                      S_AXI_RVALID,
   input  logic                      S_AXI_RREADY,
   output logic [31:0]               S_AXI_RDATA,
   output logic [1:0]                S_AXI_RRESP,
   output logic                      mem_valid,
   output logic                      mem_instr,
   input  logic                      mem_ready,
   output logic [31:0]               mem_addr,
   output logic [31:0]               mem_wdata,
   output logic [3:0]                mem_wstrb,
   input  logic [31:0]               mem_rdata
);

   if (AXI_DATA_WIDTH != 32) begin : gBadDataWidth
      $error("axil_picorv32_mem_bridge supports only AXI_DATA_WIDTH = 32");
   end

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [31:0] awAddr32;
   logic [31:0] arAddr32;

   if (AXI_ADDR_WIDTH >= 32) begin : gAddrTrunc
      assign awAddr32 = S_AXI_AWADDR[31:0];
      assign arAddr32 = S_AXI_ARADDR[31:0];
   end else begin : gAddrExt
      assign awAddr32 = {{(32 - AXI_ADDR_WIDTH){1'b0}}, S_AXI_AWADDR};
      assign arAddr32 = {{(32 - AXI_ADDR_WIDTH){1'b0}}, S_AXI_ARADDR};
   end

   logic unusedBits;
   assign unusedBits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                         awAddr32[1:0], arAddr32[1:0]};

   bridgeState_e state_q;
   logic         resetDone_q;
   logic         awFull_q, awFull_d;
   logic         wFull_q, wFull_d;
   logic [31:0]  awAddr_q;
   logic [31:0]  wData_q;
   logic [3:0]   wStrb_q;
   logic         lastGrantRd_q;
   logic [15:0]  timer_q;
   logic         memValid_q;
   logic [31:0]  memAddr_q;
   logic [31:0]  memWdata_q;
   logic [3:0]   memWstrb_q;
   logic         bValid_q;
   logic [1:0]   bResp_q;
   logic         rValid_q;
   logic [31:0]  rData_q;
   logic [1:0]   rResp_q;

   logic idle;
   logic wrPending;
   logic grantWr;
   logic grantRd;
   logic timeoutHit;

   // Round robin: a tie goes to whichever side was not granted last time.
   assign idle       = (state_q == ST_IDLE) && resetDone_q;
   assign wrPending  = awFull_q && wFull_q;
   assign grantWr    = idle && wrPending && (!S_AXI_ARVALID || lastGrantRd_q);
   assign grantRd    = idle && S_AXI_ARVALID && (!wrPending || !lastGrantRd_q);
   assign timeoutHit = (TIMEOUT_CYCLES != 0) && (timer_q == TIMEOUT_LAST);

   assign S_AXI_AWREADY = idle && !awFull_q;
   assign S_AXI_WREADY  = idle && !wFull_q;
   assign S_AXI_ARREADY = grantRd;

   always_comb begin
      awFull_d = awFull_q;
      wFull_d  = wFull_q;
      if (grantWr) begin
         awFull_d = 1'b0;
         wFull_d  = 1'b0;
      end
      if (S_AXI_AWVALID && S_AXI_AWREADY) awFull_d = 1'b1;
      if (S_AXI_WVALID && S_AXI_WREADY)   wFull_d  = 1'b1;
   end

   // AW and W are held independently so either may arrive first.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         resetDone_q <= 1'b0;
         awFull_q    <= 1'b0;
         wFull_q     <= 1'b0;
         awAddr_q    <= '0;
         wData_q     <= '0;
         wStrb_q     <= '0;
      end else begin
         resetDone_q <= 1'b1;
         awFull_q    <= awFull_d;
         wFull_q     <= wFull_d;
         if (S_AXI_AWVALID && S_AXI_AWREADY) awAddr_q <= {awAddr32[31:2], 2'b00};
         if (S_AXI_WVALID && S_AXI_WREADY) begin
            wData_q <= S_AXI_WDATA;
            wStrb_q <= S_AXI_WSTRB;
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q       <= ST_IDLE;
         lastGrantRd_q <= 1'b1;
         timer_q       <= '0;
         memValid_q    <= 1'b0;
         memAddr_q     <= '0;
         memWdata_q    <= '0;
         memWstrb_q    <= '0;
         bValid_q      <= 1'b0;
         bResp_q       <= RESP_OKAY;
         rValid_q      <= 1'b0;
         rData_q       <= '0;
         rResp_q       <= RESP_OKAY;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (grantWr) begin
                  state_q       <= ST_MEM_WR;
                  lastGrantRd_q <= 1'b0;
                  timer_q       <= '0;
                  memValid_q    <= 1'b1;
                  memAddr_q     <= awAddr_q;
                  memWdata_q    <= wData_q;
                  memWstrb_q    <= wStrb_q;
               end else if (grantRd) begin
                  state_q       <= ST_MEM_RD;
                  lastGrantRd_q <= 1'b1;
                  timer_q       <= '0;
                  memValid_q    <= 1'b1;
                  memAddr_q     <= {arAddr32[31:2], 2'b00};
                  memWdata_q    <= '0;
                  memWstrb_q    <= 4'b0000;
               end
            end
            // A completion seen on the timeout cycle still counts as OKAY.
            ST_MEM_WR, ST_MEM_RD: begin
               if (mem_ready || timeoutHit) begin
                  memValid_q <= 1'b0;
                  if (state_q == ST_MEM_WR) begin
                     state_q  <= ST_B_RESP;
                     bValid_q <= 1'b1;
                     bResp_q  <= respCode(!mem_ready);
                  end else begin
                     state_q  <= ST_R_RESP;
                     rValid_q <= 1'b1;
                     rData_q  <= mem_ready ? mem_rdata : 32'h0;
                     rResp_q  <= respCode(!mem_ready);
                  end
               end else if (timer_q != 16'hFFFF) begin
                  timer_q <= timer_q + 16'd1;
               end
            end
            ST_B_RESP: begin
               if (S_AXI_BREADY) begin
                  bValid_q <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            ST_R_RESP: begin
               if (S_AXI_RREADY) begin
                  rValid_q <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign S_AXI_BVALID = bValid_q;
   assign S_AXI_BRESP  = bResp_q;
   assign S_AXI_RVALID = rValid_q;
   assign S_AXI_RDATA  = rData_q;
   assign S_AXI_RRESP  = rResp_q;
   assign mem_valid    = memValid_q;
   assign mem_instr    = 1'b0;
   assign mem_addr     = memAddr_q;
   assign mem_wdata    = memWdata_q;
   assign mem_wstrb    = memWstrb_q;

endmodule
